// File: rtl/adma_chn_wrr_arb.sv
// Weighted-round-robin / fixed-priority channel arbiter for the multi-channel AXI DMA.
// A grant is held until it is accepted; each grant allows weight+1 consecutive bursts.
module adma_chn_wrr_arb #(
   parameter int CHN_NUM  = 4,
   parameter int CHN_ID_W = 2,
   parameter int ARB_W    = 3
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [CHN_NUM-1:0]       chn_req_i,
   input  logic [CHN_NUM-1:0]       chn_en_i,
   input  logic [CHN_NUM*ARB_W-1:0] chn_weight_i,
   input  logic                     arb_mode_i,
   output logic                     grant_valid_o,
   input  logic                     grant_ready_i,
   output logic [CHN_ID_W-1:0]      grant_id_o,
   output logic [CHN_NUM-1:0]       grant_onehot_o,
   output logic                     grant_last_o
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [CHN_NUM-1:0] ONE_VEC = CHN_NUM'(1);
   localparam logic [ARB_W:0]     CRED_ONE = (ARB_W+1)'(1);

   state_t               state_reg;
   logic [CHN_ID_W-1:0]  ptr_reg;
   logic [ARB_W:0]       credit_reg;
   logic                 valid_reg;
   logic                 last_reg;
   logic [CHN_ID_W-1:0]  id_reg;
   logic [CHN_NUM-1:0]   onehot_reg;

   logic [CHN_NUM-1:0]   elig;
   logic [CHN_NUM-1:0]   elig_ex;
   logic                 cur_elig;
   logic                 lower_elig;
   logic                 all_found;
   logic [CHN_ID_W-1:0]  all_idx;
   logic                 ex_found;
   logic [CHN_ID_W-1:0]  ex_idx;
   logic [ARB_W:0]       credit_dec;
   logic                 load_en;
   logic                 dec_en;
   logic                 drop_en;
   logic [CHN_ID_W-1:0]  load_idx;
   logic [ARB_W-1:0]     load_weight;
   logic [ARB_W:0]       load_credit;
   logic [CHN_ID_W-1:0]  ptr_next;

   // Returns {found, index}: first set bit of m scanning upward from p (wrapping),
   // or the lowest set bit when fp is high.
   function automatic logic [CHN_ID_W:0] pick(input logic [CHN_NUM-1:0] m,
                                              input logic [CHN_ID_W-1:0] p,
                                              input logic fp);
      logic                found;
      logic [CHN_ID_W-1:0] idx;
      logic [CHN_NUM-1:0]  sh;
      int                  k;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < CHN_NUM; i++) begin
         k  = fp ? i : (int'(p) + i) % CHN_NUM;
         sh = m >> k;
         if (!found && sh[0]) begin
            found = 1'b1;
            idx   = CHN_ID_W'(k);
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      elig       = chn_req_i & chn_en_i;
      elig_ex    = elig & ~onehot_reg;
      cur_elig   = |(elig & onehot_reg);
      lower_elig = |(elig & (onehot_reg - ONE_VEC));
      {all_found, all_idx} = pick(elig, ptr_reg, arb_mode_i);
      {ex_found, ex_idx}   = pick(elig_ex, ptr_reg, arb_mode_i);
      credit_dec = credit_reg - CRED_ONE;

      load_en  = 1'b0;
      dec_en   = 1'b0;
      drop_en  = 1'b0;
      load_idx = all_idx;
      case (state_reg)
         IDLE: load_en = all_found;
         GRANT: begin
            if (grant_ready_i) begin
               // In fixed-priority mode a lower index pre-empts remaining credit.
               if (arb_mode_i && lower_elig) begin
                  load_en = 1'b1;
               end else if ((credit_dec != '0) && cur_elig) begin
                  dec_en = 1'b1;
               end else if (ex_found) begin
                  load_en  = 1'b1;
                  load_idx = ex_idx;
               end else if (cur_elig) begin
                  load_en  = 1'b1;
                  load_idx = id_reg;
               end else begin
                  drop_en = 1'b1;
               end
            end
         end
         default: ;
      endcase

      load_weight = ARB_W'(chn_weight_i >> (int'(load_idx) * ARB_W));
      load_credit = (ARB_W+1)'(load_weight) + CRED_ONE;
      ptr_next    = (int'(load_idx) == CHN_NUM - 1) ? '0 : load_idx + CHN_ID_W'(1);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_reg  <= IDLE;
         ptr_reg    <= '0;
         credit_reg <= '0;
         valid_reg  <= 1'b0;
         last_reg   <= 1'b0;
         id_reg     <= '0;
         onehot_reg <= '0;
      end else if (load_en) begin
         state_reg  <= GRANT;
         valid_reg  <= 1'b1;
         id_reg     <= load_idx;
         onehot_reg <= ONE_VEC << load_idx;
         credit_reg <= load_credit;
         last_reg   <= (load_credit == CRED_ONE);
         ptr_reg    <= ptr_next;
      end else if (dec_en) begin
         credit_reg <= credit_dec;
         last_reg   <= (credit_dec == CRED_ONE);
      end else if (drop_en) begin
         state_reg  <= IDLE;
         valid_reg  <= 1'b0;
         onehot_reg <= '0;
         last_reg   <= 1'b0;
         credit_reg <= '0;
      end
   end

   assign grant_valid_o  = valid_reg;
   assign grant_id_o     = id_reg;
   assign grant_onehot_o = onehot_reg;
   assign grant_last_o   = last_reg;

endmodule

// File: tb/tb_adma_chn_wrr_arb.sv
// Self-checking bench for adma_chn_wrr_arb: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_adma_chn_wrr_arb;

   localparam int N = 4;

   logic        aclk = 1'b0;
   logic        areset;
   logic [3:0]  chn_req;
   logic [3:0]  chn_en;
   logic [11:0] chn_weight;
   logic        arb_mode;
   logic        grant_ready;
   logic        grant_valid;
   logic [1:0]  grant_id;
   logic [3:0]  grant_onehot;
   logic        grant_last;

   int n_checks = 0;
   int n_fail   = 0;

   bit m_valid;
   int m_cur;
   int m_credit;
   int m_ptr;

   always #5 aclk = ~aclk;

   adma_chn_wrr_arb #(.CHN_NUM(4), .CHN_ID_W(2), .ARB_W(3)) dut (
      .aclk           (aclk),
      .areset         (areset),
      .chn_req_i      (chn_req),
      .chn_en_i       (chn_en),
      .chn_weight_i   (chn_weight),
      .arb_mode_i     (arb_mode),
      .grant_valid_o  (grant_valid),
      .grant_ready_i  (grant_ready),
      .grant_id_o     (grant_id),
      .grant_onehot_o (grant_onehot),
      .grant_last_o   (grant_last)
   );

   function automatic bit has(input logic [3:0] e, input int k);
      return ((e >> k) & 4'd1) != 4'd0;
   endfunction

   function automatic int weight_of(input int k);
      return int'((chn_weight >> (3 * k)) & 12'h7);
   endfunction

   // WRR winner = eligible channel at the smallest forward distance from ptr;
   // fixed priority winner = smallest index.
   function automatic int model_pick(input logic [3:0] e, input int ptr, input bit fp);
      int best;
      int best_d;
      int d;
      best   = -1;
      best_d = N;
      for (int k = 0; k < N; k++) begin
         if (has(e, k)) begin
            d = fp ? k : (k - ptr + N) % N;
            if (d < best_d) begin
               best_d = d;
               best   = k;
            end
         end
      end
      return best;
   endfunction

   task automatic model_grant(input int w);
      m_valid  = 1'b1;
      m_cur    = w;
      m_credit = weight_of(w) + 1;
      m_ptr    = (w + 1) % N;
   endtask

   task automatic model_step();
      logic [3:0] e;
      int         w;
      int         lower;
      bit         cur_el;
      e = chn_req & chn_en;
      if (areset) begin
         m_valid = 1'b0; m_cur = 0; m_credit = 0; m_ptr = 0;
      end else if (!m_valid) begin
         w = model_pick(e, m_ptr, arb_mode);
         if (w >= 0) model_grant(w);
      end else if (grant_ready) begin
         cur_el = has(e, m_cur);
         lower  = -1;
         if (arb_mode)
            for (int j = 0; j < m_cur; j++)
               if (lower < 0 && has(e, j)) lower = j;
         if (lower >= 0) model_grant(lower);
         else if (m_credit - 1 > 0 && cur_el) m_credit = m_credit - 1;
         else begin
            w = model_pick(e & ~(4'b0001 << m_cur), m_ptr, arb_mode);
            if (w >= 0) model_grant(w);
            else if (cur_el) model_grant(m_cur);
            else m_valid = 1'b0;
         end
      end
   endtask

   task automatic cycle();
      if (!areset && grant_valid && grant_ready)
         $display("txn t=%0t ch=%0d last=%0b", $time, grant_id, grant_last);
      model_step();
      @(posedge aclk);
      #1;
   endtask

   task automatic apply_reset();
      areset = 1'b1;
      cycle();
      cycle();
      areset = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1; chn_req = 4'hF; chn_en = 4'hF; chn_weight = '0;
      arb_mode = 1'b0; grant_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++;
         if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", grant_valid); end
         n_checks++;
         if (grant_onehot !== 4'b0) begin n_fail++; $display("FAIL reset_onehot got=%b exp=0000", grant_onehot); end
         n_checks++;
         if (grant_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", grant_last); end
      end
      n_checks++;
      if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", grant_id); end
      areset = 1'b0;
      cycle();
      n_checks++;
      if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL reset_first_valid got=%b exp=1", grant_valid); end
      n_checks++;
      if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_first_id got=%0d exp=0", grant_id); end
   endtask

   task automatic test_wrr_weights();
      int seq[10]   = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
      bit lastv[10] = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 1};
      chn_req = 4'hF; chn_en = 4'hF; chn_weight = {3'd3, 3'd2, 3'd1, 3'd0};
      arb_mode = 1'b0; grant_ready = 1'b1;
      apply_reset();
      for (int i = 0; i < 20; i++) begin
         cycle();
         n_checks++;
         if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL wrr_valid[%0d] got=%b exp=1", i, grant_valid); end
         n_checks++;
         if (grant_id !== 2'(seq[i % 10])) begin n_fail++; $display("FAIL wrr_id[%0d] got=%0d exp=%0d", i, grant_id, seq[i % 10]); end
         n_checks++;
         if (grant_last !== lastv[i % 10]) begin n_fail++; $display("FAIL wrr_last[%0d] got=%b exp=%b", i, grant_last, lastv[i % 10]); end
      end
   endtask

   task automatic test_backpressure();
      chn_req = 4'b0100; chn_en = 4'hF; chn_weight = '0; arb_mode = 1'b0; grant_ready = 1'b0;
      apply_reset();
      cycle();
      n_checks++;
      if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin
         n_fail++; $display("FAIL bp_grant got=%b/%0d exp=1/2", grant_valid, grant_id);
      end
      chn_req = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         cycle();
         n_checks++;
         if (grant_valid !== 1'b1 || grant_id !== 2'd2 || grant_onehot !== 4'b0100) begin
            n_fail++; $display("FAIL bp_hold[%0d] got=%b/%0d/%b exp=1/2/0100", i, grant_valid, grant_id, grant_onehot);
         end
      end
      grant_ready = 1'b1;
      cycle();
      n_checks++;
      if (grant_valid !== 1'b0 || grant_onehot !== 4'b0) begin
         n_fail++; $display("FAIL bp_release got=%b/%b exp=0/0000", grant_valid, grant_onehot);
      end
      grant_ready = 1'b0;
   endtask

   task automatic test_fixed_priority();
      chn_req = 4'b1000; chn_en = 4'hF; chn_weight = {3'd3, 3'd0, 3'd0, 3'd0};
      arb_mode = 1'b1; grant_ready = 1'b0;
      apply_reset();
      cycle();
      n_checks++;
      if (grant_id !== 2'd3 || grant_last !== 1'b0) begin n_fail++; $display("FAIL fp_first got=%0d/%b exp=3/0", grant_id, grant_last); end
      grant_ready = 1'b1;
      cycle();
      n_checks++;
      if (grant_id !== 2'd3 || grant_last !== 1'b0) begin n_fail++; $display("FAIL fp_keep got=%0d/%b exp=3/0", grant_id, grant_last); end
      chn_req = 4'b1010;
      cycle();
      n_checks++;
      if (grant_id !== 2'd1 || grant_last !== 1'b1) begin n_fail++; $display("FAIL fp_preempt got=%0d/%b exp=1/1", grant_id, grant_last); end
      cycle();
      n_checks++;
      if (grant_id !== 2'd3 || grant_valid !== 1'b1) begin n_fail++; $display("FAIL fp_back got=%0d/%b exp=3/1", grant_id, grant_valid); end
      arb_mode = 1'b0;
   endtask

   task automatic test_enable_mask();
      chn_req = 4'b0010; chn_en = 4'b1101; chn_weight = '0; arb_mode = 1'b0; grant_ready = 1'b1;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         cycle();
         n_checks++;
         if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL en_masked[%0d] got=%b exp=0", i, grant_valid); end
      end
      chn_en = 4'hF;
      for (int i = 0; i < 6; i++) begin
         cycle();
         n_checks++;
         if (grant_valid !== 1'b1 || grant_id !== 2'd1 || grant_last !== 1'b1) begin
            n_fail++; $display("FAIL en_regrant[%0d] got=%b/%0d/%b exp=1/1/1", i, grant_valid, grant_id, grant_last);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      chn_req = 4'hF; chn_en = 4'hF; chn_weight = {3'd3, 3'd2, 3'd1, 3'd0};
      arb_mode = 1'b0; grant_ready = 1'b1;
      apply_reset();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         if (grant_valid === 1'b1 && grant_id === 2'd3) found = 1'b1;
      end
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL rst_mid_reach got=no_ch3 exp=ch3_within_20"); end
      areset = 1'b1;
      cycle();
      n_checks++;
      if (grant_valid !== 1'b0 || grant_onehot !== 4'b0) begin
         n_fail++; $display("FAIL rst_mid_clear got=%b/%b exp=0/0000", grant_valid, grant_onehot);
      end
      areset = 1'b0;
      cycle();
      n_checks++;
      if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
         n_fail++; $display("FAIL rst_mid_restart got=%b/%0d exp=1/0", grant_valid, grant_id);
      end
   endtask

   task automatic test_random();
      logic [3:0] exp_oh;
      chn_req = 4'hF; chn_en = 4'hF; chn_weight = 12'($urandom); arb_mode = 1'b0; grant_ready = 1'b1;
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         areset      = ($urandom_range(0, 199) == 0);
         chn_req     = 4'($urandom);
         chn_en      = 4'($urandom | $urandom);
         grant_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) chn_weight = 12'($urandom);
         if ($urandom_range(0, 15) == 0) arb_mode = ~arb_mode;
         cycle();
         exp_oh = m_valid ? (4'b0001 << m_cur) : 4'b0000;
         n_checks++;
         if (grant_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, grant_valid, m_valid); end
         if (m_valid) begin
            n_checks++;
            if (grant_id !== 2'(m_cur)) begin n_fail++; $display("FAIL rnd_id[%0d] got=%0d exp=%0d", i, grant_id, m_cur); end
         end
         n_checks++;
         if (grant_onehot !== exp_oh) begin n_fail++; $display("FAIL rnd_onehot[%0d] got=%b exp=%b", i, grant_onehot, exp_oh); end
         n_checks++;
         if (grant_last !== (m_valid && m_credit == 1)) begin
            n_fail++; $display("FAIL rnd_last[%0d] got=%b exp=%b", i, grant_last, (m_valid && m_credit == 1));
         end
      end
      areset = 1'b0;
   endtask

   initial begin
      areset = 1'b1; chn_req = '0; chn_en = '0; chn_weight = '0;
      arb_mode = 1'b0; grant_ready = 1'b0;
      m_valid = 1'b0; m_cur = 0; m_credit = 0; m_ptr = 0;
      test_reset();
      test_wrr_weights();
      test_backpressure();
      test_fixed_priority();
      test_enable_mask();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
